// File: rtl/data_chk_pkg.sv
// Shared widths, FSM state encodings and byte-mask helper for the checksum mux/splitter pair.
package data_chk_pkg;

    localparam int unsigned DATA_W = 512;
    localparam int unsigned KEEP_W = 64;
    localparam int unsigned ID_W   = 6;
    localparam int unsigned BEATS  = 4;
    localparam int unsigned ST_W   = 3;
    localparam int unsigned CNT_W  = 32;

    // Data beat k is awaited in state k; the checksum beat follows the last data beat.
    localparam logic [ST_W-1:0] ST_D0  = 3'd0;
    localparam logic [ST_W-1:0] ST_D1  = 3'd1;
    localparam logic [ST_W-1:0] ST_D2  = 3'd2;
    localparam logic [ST_W-1:0] ST_D3  = 3'd3;
    localparam logic [ST_W-1:0] ST_CHK = 3'(BEATS);

    // Zero every byte whose keep bit is clear.
    function automatic logic [DATA_W-1:0] byte_mask(
        input logic [DATA_W-1:0] data,
        input logic [KEEP_W-1:0] keep
    );
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            m[i*8 +: 8] = keep[i] ? data[i*8 +: 8] : 8'h00;
        end
        return m;
    endfunction

endpackage

// File: rtl/chk_out_slice.sv
// Single-entry valid/ready register slice for the forwarded data beats.
module chk_out_slice
    import data_chk_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic [ID_W-1:0]   in_id,
    input  logic              in_last,
    output logic              space_c,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic [ID_W-1:0]   out_id,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    // The slice can take a new beat when empty or when its current beat leaves this cycle.
    assign space_c = !out_valid || out_ready;

    // Load on accepted beat, drop valid once consumed, otherwise hold contents stable.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= in_data;
            out_keep  <= in_keep;
            out_id    <= in_id;
            out_last  <= in_last;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/data_chk_splitter.sv
// Receive-side splitter: forwards four data beats per packet, checks the trailing checksum beat.
module data_chk_splitter
    import data_chk_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic [ID_W-1:0]   in_id,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic [ID_W-1:0]   out_id,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              stat_valid,
    output logic              stat_ok,
    output logic              stat_err_chk,
    output logic              stat_err_frame,
    output logic [ID_W-1:0]   stat_id,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    logic [ST_W-1:0]   state;
    logic [ST_W-1:0]   state_nxt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] masked;
    logic [ID_W-1:0]   id_lat;
    logic              frm_sticky;
    logic              space_c;
    logic              accept;
    logic              load;
    logic              emit;
    logic              emit_chk;
    logic              emit_frame;
    logic              fwd_last;
    logic              id_mis;
    logic              keep_full;
    logic              is_d0;

    assign masked    = byte_mask(in_data, in_keep);
    assign id_mis    = (in_id != id_lat);
    assign keep_full = &in_keep;
    assign is_d0     = (state == ST_D0);
    assign in_ready  = !reset && ((state == ST_CHK) || space_c);
    assign accept    = in_valid && in_ready;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_D0;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, slice load and status decisions for the accepted beat.
    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        emit       = 1'b0;
        emit_chk   = 1'b0;
        emit_frame = 1'b0;
        fwd_last   = in_last;
        if (accept) begin
            case (state)
                ST_D0, ST_D1, ST_D2: begin
                    load = 1'b1;
                    if (in_last) begin
                        // Early end of packet: report now, no checksum beat follows.
                        emit       = 1'b1;
                        emit_frame = 1'b1;
                        state_nxt  = ST_D0;
                    end else begin
                        state_nxt = state + 3'd1;
                    end
                end
                ST_D3: begin
                    load      = 1'b1;
                    fwd_last  = 1'b1;
                    state_nxt = ST_CHK;
                end
                ST_CHK: begin
                    emit       = 1'b1;
                    emit_chk   = (acc != in_data);
                    emit_frame = frm_sticky || id_mis || !in_last || !keep_full;
                    state_nxt  = ST_D0;
                end
                default: begin
                    state_nxt = ST_D0;
                end
            endcase
        end
    end

    // Running XOR of masked data, packet id and sticky id-mismatch flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc        <= '0;
            id_lat     <= '0;
            frm_sticky <= 1'b0;
        end else if (load) begin
            if (is_d0) begin
                acc        <= masked;
                id_lat     <= in_id;
                frm_sticky <= 1'b0;
            end else begin
                acc        <= acc ^ masked;
                frm_sticky <= frm_sticky || id_mis;
            end
        end
    end

    // One-cycle status pulse and saturating packet/error counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_valid     <= 1'b0;
            stat_ok        <= 1'b0;
            stat_err_chk   <= 1'b0;
            stat_err_frame <= 1'b0;
            stat_id        <= '0;
            pkt_cnt        <= '0;
            err_cnt        <= '0;
        end else begin
            stat_valid     <= emit;
            stat_ok        <= emit && !(emit_chk || emit_frame);
            stat_err_chk   <= emit_chk;
            stat_err_frame <= emit_frame;
            stat_id        <= emit ? (is_d0 ? in_id : id_lat) : '0;
            if (emit) begin
                if (pkt_cnt != '1) begin
                    pkt_cnt <= pkt_cnt + 32'd1;
                end
                if ((emit_chk || emit_frame) && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + 32'd1;
                end
            end
        end
    end

    chk_out_slice u_out_slice (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_id     (in_id),
        .in_last   (fwd_last),
        .space_c   (space_c),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_id    (out_id),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_data_chk_splitter.sv
// Self-checking bench for data_chk_splitter: scoreboard queues for forwarded beats and status pulses.
module tb_data_chk_splitter;

    logic         clock;
    logic         reset;
    logic [511:0] in_data;
    logic [63:0]  in_keep;
    logic [5:0]   in_id;
    logic         in_last;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] out_data;
    logic [63:0]  out_keep;
    logic [5:0]   out_id;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;
    logic         stat_valid;
    logic         stat_ok;
    logic         stat_err_chk;
    logic         stat_err_frame;
    logic [5:0]   stat_id;
    logic [31:0]  pkt_cnt;
    logic [31:0]  err_cnt;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic [5:0]   id;
        logic         last;
    } beat_t;

    typedef struct {
        logic        ok;
        logic        chk;
        logic        frame;
        logic [5:0]  id;
        logic [31:0] pkt;
        logic [31:0] err;
        int          cyc;
    } stat_t;

    localparam logic [63:0] KALL = {64{1'b1}};

    beat_t q_out[$];
    stat_t q_stat[$];
    beat_t mon_b;
    stat_t mon_s;
    int    n_pass = 0;
    int    n_total = 0;
    int    m_pkt = 0;
    int    m_err = 0;
    int    cyc = 0;

    data_chk_splitter dut (
        .clock          (clock),
        .reset          (reset),
        .in_data        (in_data),
        .in_keep        (in_keep),
        .in_id          (in_id),
        .in_last        (in_last),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_keep       (out_keep),
        .out_id         (out_id),
        .out_last       (out_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .stat_valid     (stat_valid),
        .stat_ok        (stat_ok),
        .stat_err_chk   (stat_err_chk),
        .stat_err_frame (stat_err_frame),
        .stat_id        (stat_id),
        .pkt_cnt        (pkt_cnt),
        .err_cnt        (err_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Forwarded-beat and status monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            n_total++;
            if (q_out.size() == 0) begin
                $display("FAIL out_extra: unexpected beat data=%h", out_data);
            end else begin
                n_pass++;
                mon_b = q_out.pop_front();
                n_total++;
                if (out_data !== mon_b.data) $display("FAIL out_data: got %h want %h", out_data, mon_b.data);
                else n_pass++;
                n_total++;
                if (out_keep !== mon_b.keep) $display("FAIL out_keep: got %h want %h", out_keep, mon_b.keep);
                else n_pass++;
                n_total++;
                if (out_id !== mon_b.id) $display("FAIL out_id: got %0d want %0d", out_id, mon_b.id);
                else n_pass++;
                n_total++;
                if (out_last !== mon_b.last) $display("FAIL out_last: got %b want %b", out_last, mon_b.last);
                else n_pass++;
            end
        end
        if (!reset && stat_valid) begin
            n_total++;
            if (q_stat.size() == 0) begin
                $display("FAIL stat_extra: unexpected status pulse at cycle %0d", cyc);
            end else begin
                n_pass++;
                mon_s = q_stat.pop_front();
                n_total++;
                if ({stat_ok, stat_err_chk, stat_err_frame} !== {mon_s.ok, mon_s.chk, mon_s.frame})
                    $display("FAIL stat_flags: got ok/chk/frame=%b%b%b want %b%b%b",
                             stat_ok, stat_err_chk, stat_err_frame, mon_s.ok, mon_s.chk, mon_s.frame);
                else n_pass++;
                n_total++;
                if (stat_id !== mon_s.id) $display("FAIL stat_id: got %0d want %0d", stat_id, mon_s.id);
                else n_pass++;
                n_total++;
                if (pkt_cnt !== mon_s.pkt) $display("FAIL pkt_cnt: got %0d want %0d", pkt_cnt, mon_s.pkt);
                else n_pass++;
                n_total++;
                if (err_cnt !== mon_s.err) $display("FAIL err_cnt: got %0d want %0d", err_cnt, mon_s.err);
                else n_pass++;
                n_total++;
                if (cyc !== mon_s.cyc) $display("FAIL stat_timing: got cycle %0d want %0d", cyc, mon_s.cyc);
                else n_pass++;
            end
        end
    end

    // Offer one beat, wait for acceptance and push the expected outcomes.
    task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic [5:0] id,
                             input logic last, input bit fwd, input logic exp_last, input bit st,
                             input logic e_chk, input logic e_frame, input logic [5:0] e_id,
                             output int waited);
        bit got;
        in_data  = d;
        in_keep  = k;
        in_id    = id;
        in_last  = last;
        in_valid = 1'b1;
        waited   = 0;
        got      = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clock);
            if (in_ready) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            n_total++;
            $display("FAIL accept_timeout: in_ready stayed %b, want 1", in_ready);
        end else begin
            if (fwd) q_out.push_back('{d, k, id, exp_last});
            if (st) begin
                m_pkt++;
                if (e_chk || e_frame) m_err++;
                q_stat.push_back('{!(e_chk || e_frame), e_chk, e_frame, e_id,
                                   32'(m_pkt), 32'(m_err), cyc + 1});
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Four data beats (full keep) followed by a checksum beat.
    task automatic send_pkt(input logic [511:0] d0, d1, d2, d3, input logic [5:0] id,
                            input logic [5:0] id3, input logic [511:0] chk, input logic [63:0] ck,
                            input logic cl, input logic e_chk, input logic e_frame);
        int w;
        send_beat(d0, KALL, id, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, id, w);
        send_beat(d1, KALL, id, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, id, w);
        send_beat(d2, KALL, id, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, id, w);
        send_beat(d3, KALL, id3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, id, w);
        send_beat(chk, ck, id, cl, 1'b0, 1'b0, 1'b1, e_chk, e_frame, id, w);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready);
        else n_pass++;
        n_total++;
        if ({out_valid, out_last, out_keep, out_id} !== 72'd0 || out_data !== 512'd0)
            $display("FAIL reset_out: got valid=%b last=%b keep=%h id=%0d", out_valid, out_last, out_keep, out_id);
        else n_pass++;
        n_total++;
        if ({stat_valid, stat_ok, stat_err_chk, stat_err_frame, stat_id} !== 10'd0)
            $display("FAIL reset_stat: got %b%b%b%b id=%0d", stat_valid, stat_ok, stat_err_chk, stat_err_frame, stat_id);
        else n_pass++;
        n_total++;
        if ({pkt_cnt, err_cnt} !== 64'd0) $display("FAIL reset_cnt: got pkt=%0d err=%0d want 0 0", pkt_cnt, err_cnt);
        else n_pass++;
        reset = 1'b0;
        m_pkt = 0;
        m_err = 0;
        @(posedge clock);
        #1;
    endtask

    task automatic check_counts(input logic [31:0] p, input logic [31:0] e);
        @(negedge clock);
        n_total++;
        if (pkt_cnt !== p || err_cnt !== e)
            $display("FAIL counters: got pkt=%0d err=%0d want pkt=%0d err=%0d", pkt_cnt, err_cnt, p, e);
        else n_pass++;
        @(posedge clock);
        #1;
    endtask

    task automatic test_clean();
        send_pkt(512'h1, 512'h2, 512'h4, 512'h8, 6'd5, 6'd5, 512'hF, KALL, 1'b1, 1'b0, 1'b0);
        check_counts(32'd1, 32'd0);
    endtask

    task automatic test_bad_chk();
        send_pkt(512'h1, 512'h2, 512'h4, 512'h8, 6'd5, 6'd5, 512'hE, KALL, 1'b1, 1'b1, 1'b0);
        check_counts(32'd2, 32'd1);
    endtask

    task automatic test_stall();
        fork
            send_pkt(512'h10, 512'h20, 512'h40, 512'h80, 6'd5, 6'd5, 512'hF0, KALL, 1'b1, 1'b0, 1'b0);
            begin
                repeat (2) @(posedge clock);
                #1;
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clock);
                    n_total++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 512'h20)
                        $display("FAIL stall_hold: in_ready=%b out_valid=%b out_data=%h want 0 1 20",
                                 in_ready, out_valid, out_data);
                    else n_pass++;
                end
                @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        check_counts(32'd3, 32'd1);
    endtask

    task automatic test_chk_ready();
        int w;
        send_beat(512'h3, KALL, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd9, w);
        send_beat(512'h5, KALL, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd9, w);
        send_beat(512'h9, KALL, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd9, w);
        send_beat(512'h11, KALL, 6'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd9, w);
        out_ready = 1'b0;
        send_beat(512'h1E, KALL, 6'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd9, w);
        n_total++;
        if (w !== 0) $display("FAIL chk_ready: checksum beat waited %0d cycles want 0", w);
        else n_pass++;
        out_ready = 1'b1;
        check_counts(32'd4, 32'd1);
    endtask

    task automatic test_early_last();
        int w;
        send_beat(512'hA1, KALL, 6'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd5, w);
        send_beat(512'hA2, KALL, 6'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd5, w);
        send_beat(512'hA3, KALL, 6'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'd5, w);
        check_counts(32'd5, 32'd2);
        send_pkt(512'h1, 512'h2, 512'h4, 512'h8, 6'd5, 6'd5, 512'hF, KALL, 1'b1, 1'b0, 1'b0);
        check_counts(32'd6, 32'd2);
    endtask

    task automatic test_frame_errors();
        send_pkt(512'h1, 512'h2, 512'h4, 512'h8, 6'd5, 6'd6, 512'hF, KALL, 1'b1, 1'b0, 1'b1);
        send_pkt(512'h1, 512'h2, 512'h4, 512'h8, 6'd5, 6'd5, 512'hF, 64'h0FFF_FFFF_FFFF_FFFF,
                 1'b1, 1'b0, 1'b1);
        send_pkt(512'h1, 512'h2, 512'h4, 512'h8, 6'd7, 6'd7, 512'hF, KALL, 1'b0, 1'b0, 1'b1);
        check_counts(32'd9, 32'd5);
    endtask

    task automatic test_keep_mask();
        int w;
        logic [511:0] v;
        v = 512'h20;
        v[511:504] = 8'hC3;
        send_beat(512'h1FF, 64'hFFFF_FFFF_FFFF_FFFE, 6'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3, w);
        send_beat(512'h10, KALL, 6'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3, w);
        send_beat(v, {1'b0, {63{1'b1}}}, 6'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3, w);
        send_beat(512'hAB00, KALL, 6'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd3, w);
        send_beat(512'hAA30, KALL, 6'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd3, w);
        check_counts(32'd10, 32'd5);
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = cyc;
        send_pkt(512'h100, 512'h200, 512'h400, 512'h800, 6'd1, 6'd1, 512'hF00, KALL, 1'b1, 1'b0, 1'b0);
        send_pkt(512'h7, 512'h70, 512'h700, 512'h7000, 6'd2, 6'd2, 512'h7776, KALL, 1'b1, 1'b1, 1'b0);
        n_total++;
        if (cyc - c0 !== 10) $display("FAIL throughput: 10 beats took %0d cycles want 10", cyc - c0);
        else n_pass++;
        check_counts(32'd12, 32'd6);
    endtask

    task automatic test_reset_mid();
        int w;
        send_beat(512'hB0, KALL, 6'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd4, w);
        send_beat(512'hB1, KALL, 6'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd4, w);
        send_beat(512'hB2, KALL, 6'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd4, w);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 512'd0 || stat_valid !== 1'b0)
            $display("FAIL reset_mid_out: in_ready=%b out_valid=%b stat_valid=%b want 0 0 0",
                     in_ready, out_valid, stat_valid);
        else n_pass++;
        n_total++;
        if ({pkt_cnt, err_cnt} !== 64'd0) $display("FAIL reset_mid_cnt: got pkt=%0d err=%0d want 0 0", pkt_cnt, err_cnt);
        else n_pass++;
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_pkt = 0;
        m_err = 0;
        send_pkt(512'h1, 512'h2, 512'h4, 512'h8, 6'd5, 6'd5, 512'hF, KALL, 1'b1, 1'b0, 1'b0);
        check_counts(32'd1, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_keep   = '0;
        in_id     = '0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_clean();
        test_bad_chk();
        test_stall();
        test_chk_ready();
        test_early_last();
        test_frame_errors();
        test_keep_mask();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(posedge clock);
        #1;
        n_total++;
        if (q_out.size() !== 0) $display("FAIL out_drain: %0d beats never forwarded, want 0", q_out.size());
        else n_pass++;
        n_total++;
        if (q_stat.size() !== 0) $display("FAIL stat_drain: %0d status pulses missing, want 0", q_stat.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
